// File: rtl/rs232out_fifo_if.sv
// rs232out_fifo_if: bundles the producer-side write port and the consumer-side
// serialiser handshake of rs232out_fifo.
//   in_w/in_d           producer write strobe and byte
//   in_full/count       buffer occupancy status
//   overflow            sticky "write while full" flag
//   tx_w/tx_d/tx_busy   strobe, byte and busy of the rs232out serialiser
//   drop_count/high_water  statistics, present only with RS232_TXFIFO_STATS_EN
// Modports: slave = the FIFO itself, master = whoever drives producer and busy.
interface rs232out_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  in_w;
   logic [7:0]            in_d;
   logic                  in_full;
   logic [DEPTH_LOG2:0]   count;
   logic                  overflow;
   logic                  tx_w;
   logic [7:0]            tx_d;
   logic                  tx_busy;
`ifdef RS232_TXFIFO_STATS_EN
   logic [15:0]           drop_count;
   logic [DEPTH_LOG2:0]   high_water;
`endif

`ifdef RS232_TXFIFO_STATS_EN
   modport slave (
      input  in_w, in_d, tx_busy,
      output in_full, count, overflow, tx_w, tx_d, drop_count, high_water
   );
   modport master (
      output in_w, in_d, tx_busy,
      input  in_full, count, overflow, tx_w, tx_d, drop_count, high_water
   );
`else
   modport slave (
      input  in_w, in_d, tx_busy,
      output in_full, count, overflow, tx_w, tx_d
   );
   modport master (
      output in_w, in_d, tx_busy,
      input  in_full, count, overflow, tx_w, tx_d
   );
`endif
endinterface

// File: rtl/rs232out_fifo.sv
// rs232out_fifo: transmit byte buffer between the rs232 peripheral and the
// rs232out serialiser. Absorbs bursts of CPU writes and hands one byte at a
// time to the serialiser whenever it is idle.
// Ports:
//   clock   system clock, all state on posedge
//   rst_n   asynchronous active-low reset
//   bus     rs232out_fifo_if.slave: in_w/in_d in, in_full/count/overflow out,
//           tx_w/tx_d out, tx_busy in (plus drop_count/high_water with stats)
// Optional feature: define RS232_TXFIFO_STATS_EN to add drop_count (saturating
// count of dropped pushes) and high_water (peak occupancy since reset).
module rs232out_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                 clock,
   input  logic                 rst_n,
   rs232out_fifo_if.slave       bus
);
   localparam int unsigned          DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]  FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GUARD = 1'b1;

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  tx_w_q, tx_w_d;
   logic [7:0]            tx_d_q, tx_d_d;
   logic [0:0]            state_q, state_d;

   logic full, push, drop, pop;

   // Full, push and drop all use the pre-cycle count, so a write while full is
   // dropped even if a pop frees a slot on the same edge.
   assign full = (count_q == FULL_CNT);
   assign push = bus.in_w & ~full;
   assign drop = bus.in_w & full;
   // S_GUARD masks the cycle before rs232out has raised busy for the last byte.
   assign pop  = (state_q == S_IDLE) & (count_q != '0) & ~bus.tx_busy;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | drop;
      tx_w_d     = pop;
      tx_d_d     = tx_d_q;
      state_d    = S_IDLE;

      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
         tx_d_d   = mem_q[rd_ptr_q];
         state_d  = S_GUARD;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
         2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         tx_w_q     <= 1'b0;
         tx_d_q     <= '0;
         state_q    <= S_IDLE;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         tx_w_q     <= tx_w_d;
         tx_d_q     <= tx_d_d;
         state_q    <= state_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by count_q/pointers only.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_d;
   end

   assign bus.in_full  = full;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
   assign bus.tx_w     = tx_w_q;
   assign bus.tx_d     = tx_d_q;

`ifdef RS232_TXFIFO_STATS_EN
   logic [15:0]         drop_count_q, drop_count_d;
   logic [DEPTH_LOG2:0] high_water_q, high_water_d;

   always_comb begin
      drop_count_d = drop_count_q;
      high_water_d = high_water_q;
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
      if (count_d > high_water_q) high_water_d = count_d;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         drop_count_q <= '0;
         high_water_q <= '0;
      end else begin
         drop_count_q <= drop_count_d;
         high_water_q <= high_water_d;
      end
   end

   assign bus.drop_count = drop_count_q;
   assign bus.high_water = high_water_q;
`endif
endmodule

// File: tb/tb_rs232out_fifo.sv
// tb_rs232out_fifo: directed self-checking bench for rs232out_fifo.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_rs232out_fifo;
   logic clock;
   logic rst_n;
   int   passed;
   int   total;
   int   fails;

   rs232out_fifo_if #(.DEPTH_LOG2(4)) bus ();

   rs232out_fifo #(.DEPTH_LOG2(4)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus.in_w = 1'b1;
      bus.in_d = b;
      tick();
      bus.in_w = 1'b0;
   endtask

   initial begin
      int got;
      int last;
      int rcv;
      int sent;
      int seen;
      logic busy_edge;
      logic [15:0] lfsr;

      passed = 0; total = 0; fails = 0;
      rst_n = 1'b0;
      bus.in_w = 1'b0; bus.in_d = '0; bus.tx_busy = 1'b0;
      repeat (3) tick();

      // reset state
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_full", 32'(bus.in_full), 0);
      chk("rst_ovf", 32'(bus.overflow), 0);
      chk("rst_tx_w", 32'(bus.tx_w), 0);
      chk("rst_tx_d", 32'(bus.tx_d), 0);
`ifdef RS232_TXFIFO_STATS_EN
      chk("rst_drop", 32'(bus.drop_count), 0);
      chk("rst_hw", 32'(bus.high_water), 0);
`endif
      rst_n = 1'b1;
      tick();

      // single byte latency
      push_byte(8'h41);
      chk("t1_count1", 32'(bus.count), 1);
      chk("t1_no_early_tx", 32'(bus.tx_w), 0);
      tick();
      chk("t1_tx_w", 32'(bus.tx_w), 1);
      chk("t1_tx_d", 32'(bus.tx_d), 32'h41);
      chk("t1_count0", 32'(bus.count), 0);
      tick();
      chk("t1_tx_w_one_cycle", 32'(bus.tx_w), 0);
      chk("t1_tx_d_hold", 32'(bus.tx_d), 32'h41);

      // fill with busy held
      bus.tx_busy = 1'b1;
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      chk("t2_count16", 32'(bus.count), 16);
      chk("t2_full", 32'(bus.in_full), 1);
      chk("t2_no_ovf", 32'(bus.overflow), 0);
      chk("t2_no_tx_busy", 32'(bus.tx_w), 0);

      // write while full
      push_byte(8'hAA);
      chk("t3_ovf", 32'(bus.overflow), 1);
      chk("t3_count16", 32'(bus.count), 16);
`ifdef RS232_TXFIFO_STATS_EN
      chk("t3_drop", 32'(bus.drop_count), 1);
      chk("t3_hw", 32'(bus.high_water), 16);
`endif

      // drain in order
      bus.tx_busy = 1'b0;
      got = 0; last = -10;
      for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
         tick();
         if (bus.tx_w) begin
            chk("t2_order", 32'(bus.tx_d), 32'(got));
            chk("t2_gap_ok", 32'(cyc - last >= 2), 1);
            got++;
            last = cyc;
         end
      end
      chk("t2_drained", 32'(got), 16);
      tick();
      chk("t2_empty", 32'(bus.count), 0);
      chk("t2_not_full", 32'(bus.in_full), 0);

      // simultaneous push/pop at 5
      bus.tx_busy = 1'b1;
      for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i));
      chk("t5_count5_pre", 32'(bus.count), 5);
      bus.tx_busy = 1'b0;
      push_byte(8'h55);
      bus.tx_busy = 1'b1;
      chk("t5_count5", 32'(bus.count), 5);
      chk("t5_tx_w", 32'(bus.tx_w), 1);
      chk("t5_tx_d", 32'(bus.tx_d), 32'h50);
      tick();
      chk("t5_count5_hold", 32'(bus.count), 5);

      // simultaneous push/pop at 16
      for (int i = 0; i < 11; i++) push_byte(8'(8'h60 + i));
      chk("t5_count16", 32'(bus.count), 16);
      bus.tx_busy = 1'b0;
      push_byte(8'hEE);
      bus.tx_busy = 1'b1;
      chk("t5_count15", 32'(bus.count), 15);
      chk("t5_full_tx_d", 32'(bus.tx_d), 32'h51);
`ifdef RS232_TXFIFO_STATS_EN
      chk("t5_drop2", 32'(bus.drop_count), 2);
`endif
      tick();
      chk("t5_count15_hold", 32'(bus.count), 15);

      // reset mid-burst
      bus.tx_busy = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("t6_count0", 32'(bus.count), 0);
      chk("t6_tx_w0", 32'(bus.tx_w), 0);
      chk("t6_ovf0", 32'(bus.overflow), 0);
      rst_n = 1'b1;
      tick();
      bus.tx_busy = 1'b1;
      for (int i = 0; i < 7; i++) push_byte(8'(8'h70 + i));
      bus.tx_busy = 1'b0;
      push_byte(8'h77);
      chk("t6_count7", 32'(bus.count), 7);
      chk("t6_pre_tx_w", 32'(bus.tx_w), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_mid_count0", 32'(bus.count), 0);
      chk("t6_mid_tx_w0", 32'(bus.tx_w), 0);
      chk("t6_mid_tx_d0", 32'(bus.tx_d), 0);
      chk("t6_mid_full0", 32'(bus.in_full), 0);
`ifdef RS232_TXFIFO_STATS_EN
      chk("t6_drop0", 32'(bus.drop_count), 0);
      chk("t6_hw0", 32'(bus.high_water), 0);
`endif
      tick();
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.tx_w) seen++;
      end
      chk("t6_no_tx_after_rst", 32'(seen), 0);
      chk("t6_still_empty", 32'(bus.count), 0);
      push_byte(8'h99);
      tick();
      chk("t6_new_tx_w", 32'(bus.tx_w), 1);
      chk("t6_new_tx_d", 32'(bus.tx_d), 32'h99);
      tick();

      // wrap with pseudo-random busy
      lfsr = 16'hACE1;
      rcv = 0; sent = 0; last = -10;
      for (int cyc = 0; cyc < 3000 && rcv < 40; cyc++) begin
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         bus.tx_busy = lfsr[0];
         busy_edge = lfsr[0];
         if (sent < 40 && !bus.in_full && lfsr[5]) begin
            bus.in_w = 1'b1;
            bus.in_d = 8'(sent);
            sent++;
         end else begin
            bus.in_w = 1'b0;
         end
         tick();
         if (bus.tx_w) begin
            chk("t4_order", 32'(bus.tx_d), 32'(rcv));
            chk("t4_busy_low", 32'(busy_edge), 0);
            chk("t4_gap_ok", 32'(cyc - last >= 2), 1);
            rcv++;
            last = cyc;
         end
      end
      bus.in_w = 1'b0;
      bus.tx_busy = 1'b0;
      chk("t4_all_received", 32'(rcv), 40);
      tick();
      tick();
      chk("t4_empty", 32'(bus.count), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
